// File: rtl/tb_cmd_dispatcher_if.sv
// Command and collaborator bus between a scenario reader and tb_cmd_dispatcher.
// The master side issues commands and drives the collaborator completion lines.
interface tb_cmd_dispatcher_if #(
  parameter int unsigned NB_CHANNELS = 4,
  parameter int unsigned CHAN_W      = 2,
  parameter int unsigned ARG_W       = 32,
  parameter int unsigned TO_W        = 16,
  parameter int unsigned ERR_W       = 8
) ();
  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic [2:0]             i_cmd_op;
  logic [CHAN_W-1:0]      i_cmd_chan;
  logic [ARG_W-1:0]       i_cmd_arg;
  logic [TO_W-1:0]        i_cmd_timeout;
  logic [NB_CHANNELS-1:0] o_sel_set;
  logic [NB_CHANNELS-1:0] o_sel_wait;
  logic                   o_wait_fall;
  logic [NB_CHANNELS-1:0] o_sel_check;
  logic [ARG_W-1:0]       o_arg;
  logic [NB_CHANNELS-1:0] i_wait_done;
  logic [NB_CHANNELS-1:0] i_check_done;
  logic [NB_CHANNELS-1:0] i_check_ok;
  logic                   o_ack;
  logic [1:0]             o_status;
  logic [ERR_W-1:0]       o_err_cnt;
  logic                   o_busy;

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_chan, i_cmd_arg, i_cmd_timeout,
    output i_wait_done, i_check_done, i_check_ok,
    input  o_cmd_ready, o_sel_set, o_sel_wait, o_wait_fall, o_sel_check, o_arg,
    input  o_ack, o_status, o_err_cnt, o_busy
  );

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_chan, i_cmd_arg, i_cmd_timeout,
    input  i_wait_done, i_check_done, i_check_ok,
    output o_cmd_ready, o_sel_set, o_sel_wait, o_wait_fall, o_sel_check, o_arg,
    output o_ack, o_status, o_err_cnt, o_busy
  );
endinterface

// File: rtl/tb_cmd_dispatcher.sv
// Sequenced command dispatcher: accepts one scenario command per handshake, routes it
// to a SET/WAIT/CHECK channel or a delay, and reports completion with ack + status.
module tb_cmd_dispatcher #(
  parameter int unsigned NB_CHANNELS = 4,
  parameter int unsigned CHAN_W      = 2,
  parameter int unsigned ARG_W       = 32,
  parameter int unsigned TO_W        = 16,
  parameter int unsigned ERR_W       = 8
) (
  input logic                clk,
  input logic                rst_n,
  tb_cmd_dispatcher_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_SET, S_WAIT, S_CHECK, S_DELAY, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_NOP = 3'd0, OP_SET = 3'd1, OP_WTR = 3'd2, OP_WTF = 3'd3, OP_CHK = 3'd4, OP_DLY = 3'd5
  } op_e;
  typedef enum logic [1:0] {ST_OK, ST_TIMEOUT, ST_CHKFAIL, ST_BADCMD} status_e;

  state_e            state_q, state_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic [ARG_W-1:0]  arg_q, arg_d;
  logic [TO_W-1:0]   lim_q, lim_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              fall_q, fall_d;
  status_e           status_q, status_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic [NB_CHANNELS-1:0] onehot;
  logic                   chan_ok;
  logic [TO_W-1:0]        dly_lim;
  logic                   expired;
  logic                   wait_hit, chk_hit, chk_pass;
  logic                   finish;
  status_e                fin_status;

  // Done/ok inputs are masked rather than indexed so CHAN_W may exceed clog2(NB_CHANNELS).
  assign onehot   = NB_CHANNELS'(1) << chan_q;
  assign wait_hit = |(bus.i_wait_done & onehot);
  assign chk_hit  = |(bus.i_check_done & onehot);
  assign chk_pass = |(bus.i_check_ok & onehot);
  assign chan_ok  = 32'(bus.i_cmd_chan) < NB_CHANNELS;
  assign dly_lim  = (bus.i_cmd_arg[TO_W-1:0] == '0) ? TO_W'(1) : bus.i_cmd_arg[TO_W-1:0];
  // lim_q doubles as timeout (WAIT/CHECK) and delay length (DELAY); 0 only means "no timeout".
  assign expired  = (lim_q != '0) && (cnt_q == lim_q - TO_W'(1));

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    arg_d      = arg_q;
    lim_d      = lim_q;
    cnt_d      = cnt_q;
    fall_d     = fall_q;
    status_d   = status_q;
    err_d      = err_q;
    finish     = 1'b0;
    fin_status = ST_OK;

    case (state_q)
      S_IDLE: begin
        if (bus.i_cmd_valid) begin
          chan_d = bus.i_cmd_chan;
          arg_d  = bus.i_cmd_arg;
          lim_d  = bus.i_cmd_timeout;
          fall_d = (bus.i_cmd_op == OP_WTF);
          cnt_d  = '0;
          case (bus.i_cmd_op)
            OP_NOP: finish = 1'b1;
            OP_DLY: begin
              state_d = S_DELAY;
              lim_d   = dly_lim;
            end
            OP_SET, OP_WTR, OP_WTF, OP_CHK: begin
              if (!chan_ok) begin
                finish     = 1'b1;
                fin_status = ST_BADCMD;
              end else if (bus.i_cmd_op == OP_SET) begin
                state_d = S_SET;
              end else if (bus.i_cmd_op == OP_CHK) begin
                state_d = S_CHECK;
              end else begin
                state_d = S_WAIT;
              end
            end
            default: begin
              finish     = 1'b1;
              fin_status = ST_BADCMD;
            end
          endcase
        end
      end
      S_SET: finish = 1'b1;
      S_WAIT: begin
        if (wait_hit) begin
          finish = 1'b1;
        end else if (expired) begin
          finish     = 1'b1;
          fin_status = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_CHECK: begin
        if (chk_hit) begin
          finish     = 1'b1;
          fin_status = chk_pass ? ST_OK : ST_CHKFAIL;
        end else if (expired) begin
          finish     = 1'b1;
          fin_status = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_DELAY: begin
        if (cnt_q == lim_q - TO_W'(1)) finish = 1'b1;
        else                           cnt_d  = cnt_q + TO_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d  = S_DONE;
      status_d = fin_status;
      if (fin_status != ST_OK && err_q != '1) err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      chan_q   <= '0;
      arg_q    <= '0;
      lim_q    <= '0;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
      status_q <= ST_OK;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      arg_q    <= arg_d;
      lim_q    <= lim_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_cmd_ready = (state_q == S_IDLE);
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_sel_set   = (state_q == S_SET)   ? onehot : '0;
  assign bus.o_sel_wait  = (state_q == S_WAIT)  ? onehot : '0;
  assign bus.o_sel_check = (state_q == S_CHECK) ? onehot : '0;
  assign bus.o_wait_fall = (state_q == S_WAIT) && fall_q;
  assign bus.o_arg       = arg_q;
  assign bus.o_ack       = (state_q == S_DONE);
  assign bus.o_status    = status_q;
  assign bus.o_err_cnt   = err_q;

endmodule

// File: doc/tb_cmd_dispatcher.md
Name: tb_cmd_dispatcher

Overview:
Parametrised test-bench command dispatcher. It accepts one encoded scenario command per valid/ready handshake and routes it to one of NB_CHANNELS SET/WAIT/CHECK collaborator channels. It tracks completion with a per-command timeout and returns a single ack pulse plus a status code to the scenario reader. It replaces the previous purely combinational selection with a sequenced, handshaked, multi-channel dispatcher that supports timeouts and delays.

Parameters:
NB_CHANNELS, 4, number of collaborator channels (1..16)
CHAN_W, 2, channel index width, must be >= clog2(NB_CHANNELS), minimum 1
ARG_W, 32, command argument width
TO_W, 16, timeout and delay counter width
ERR_W, 8, error counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  dispatcher can accept a command
i_cmd_op  in  3  opcode: 0 NOP, 1 SET, 2 WTR, 3 WTF, 4 CHK, 5 DLY, 6-7 illegal
i_cmd_chan  in  CHAN_W  target channel
i_cmd_arg  in  ARG_W  SET/CHK value, or DLY cycle count (low TO_W bits)
i_cmd_timeout  in  TO_W  max cycles for WTR/WTF/CHK; 0 means no timeout
o_sel_set  out  NB_CHANNELS  one-hot 1-cycle pulse
o_sel_wait  out  NB_CHANNELS  one-hot level, held while waiting
o_wait_fall  out  1  0 = wait for rising edge, 1 = falling edge; valid while o_sel_wait != 0
o_sel_check  out  NB_CHANNELS  one-hot level, held while checking
o_arg  out  ARG_W  registered argument of the current command
i_wait_done  in  NB_CHANNELS  per-channel wait complete
i_check_done  in  NB_CHANNELS  per-channel check complete
i_check_ok  in  NB_CHANNELS  per-channel check result, sampled with done
o_ack  out  1  1-cycle completion pulse
o_status  out  2  0 OK, 1 TIMEOUT, 2 CHECK_FAIL, 3 BAD_CMD; valid with o_ack, held until the next ack
o_err_cnt  out  ERR_W  saturating count of non-OK completions
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE, o_cmd_ready=1, all o_sel_*=0, o_wait_fall=0, o_arg=0, o_ack=0, o_status=0, o_err_cnt=0, o_busy=0.
- States: IDLE, SET, WAIT, CHECK, DELAY, DONE.
- Accept: i_cmd_valid & o_cmd_ready at a rising edge. op/chan/arg/timeout are registered at that edge. o_cmd_ready=1 only in IDLE and drops on the cycle after accept.
- Command validity check is done at accept. BAD_CMD if the op is illegal or chan >= NB_CHANNELS (op != NOP/DLY). BAD_CMD goes straight to DONE; no select is asserted.
- NOP goes to DONE with status OK.
- SET: o_sel_set[chan] high for exactly 1 cycle (SET state), then DONE with OK.
- WTR/WTF: o_sel_wait[chan]=1 and o_wait_fall=(op==WTF) throughout WAIT.
  - Exit to DONE/OK on the first cycle i_wait_done[chan]=1.
  - Done inputs of other channels are ignored.
- CHK: o_sel_check[chan]=1 throughout CHECK. On i_check_done[chan]=1, go to DONE with OK if i_check_ok[chan]=1, else CHECK_FAIL.
- Timeout in WAIT/CHECK:
  - Counter is cleared on entry and increments each cycle without done.
  - When the count reaches timeout-1 with no done, go to DONE with TIMEOUT (total of `timeout` cycles in state).
  - If done and expiry occur in the same cycle, done wins (OK or CHECK_FAIL).
  - timeout=0 means wait indefinitely.
- DLY: stay in DELAY for max(arg[TO_W-1:0],1) cycles, then DONE/OK. No selects are asserted.
- DONE lasts 1 cycle: o_ack=1, o_status updated, all selects 0. The following cycle is IDLE with ready=1.
- Minimum command-to-command spacing: accept -> op state (>=1 cycle) -> DONE -> IDLE.
- o_err_cnt increments on every DONE whose status != OK and saturates at all-ones.
- Reset asserted mid-command aborts immediately to reset values with no ack.
- Only one select bit across all o_sel_* vectors is ever high at a time.

Test Plan:
- After reset, SET chan 2 arg 0xA5 -> o_sel_set=4'b0100 for 1 cycle, o_arg=0xA5, o_ack 1 cycle later with status 0; ready back high the next cycle.
- WTF chan 1, timeout 10, i_wait_done[1] raised after 4 cycles, other channels toggling done -> o_sel_wait=4'b0010 and o_wait_fall=1 until done, ack status 0, o_err_cnt=0.
- WTR chan 0, timeout 5, done never raised -> exactly 5 cycles in WAIT, ack status 1, o_err_cnt=1. Repeat with done arriving on cycle 5 -> status 0.
- CHK chan 3 with i_check_ok=0 at done -> status 2; op=7 and chan=5 with NB_CHANNELS=4 -> each gives immediate ack status 3 with no select asserted; ERR_W=2 forced past 3 errors -> o_err_cnt stays 3.
- DLY arg 0 -> ack after 1 DELAY cycle; DLY arg 20 -> ack after 20 DELAY cycles; i_cmd_valid held high the whole time -> only one accept per command.
- Pull rst_n low during a WAIT with timeout 0 -> all outputs reset asynchronously, no ack; after release, a new SET completes normally.
